washer_fsm: RTL and testbench
=============================

# washer_fsm

Top-level mode controller of the washing machine. Turns the power, start/pause and lid-switch inputs, plus the countdown status flags returned by the run/countdown stage, into the 3-bit `state` bus that the run/countdown stage and the display consume. It sits directly upstream of the run/countdown stage and closes the loop with it: this block drives `state`, the run stage returns `hadFinish`, `initTime` and `finishTime`.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable `clk` cycles required before a button level is accepted. Production builds use 500_000; 16 is for simulation.
- `clk`  in  1  system clock, the same fast clock the run stage divides to 1 Hz.
- `rst`  in  1  reset, asynchronous and active-high.
- `powerBtn`  in  1  raw power push-button, asynchronous, active-high.
- `startBtn`  in  1  raw start/pause push-button, asynchronous, active-high.
- `lidOpen`  in  1  raw lid switch level, asynchronous; 1 = open.
- `hadFinish`  in  1  from the run stage; wash program complete.
- `initTime`  in  3  from the run stage; power-on countdown, 5 down to 0.
- `finishTime`  in  3  from the run stage; end-of-wash countdown, 5 down to 0.
- `state`  out  3  current mode, registered.
- `alarm`  out  1  registered; 1 while `state` is errorST or finishST.

## Operation
- State encoding: shutDownST=0, beginST=1, setST=2, runST=3, errorST=4, pauseST=5, finishST=6. Code 7 is illegal and recovers to shutDownST on the next clock.
- Each button passes through a 2-FF synchronizer, then the debounce filter, then a rising-edge detector, which produces a 1-cycle pulse (`pwrP`, `stP`). `lidOpen` gets a 2-FF synchronizer only (`lidS`).
- Transitions. Priority within a row is left to right; no condition means hold.
  - shutDownST: `pwrP` -> beginST.
  - beginST: `pwrP` -> shutDownST; `initTime`==0 with `armed` set -> setST.
  - setST: `pwrP` -> shutDownST; `stP` -> runST.
  - runST: `pwrP` -> shutDownST; `lidS` -> errorST; `hadFinish` -> finishST; `stP` -> pauseST.
  - pauseST: `pwrP` -> shutDownST; `stP` with `lidS`==0 -> runST. `stP` while the lid is open is ignored.
  - errorST: `pwrP` -> shutDownST; `lidS`==0 -> pauseST. It never returns directly to runST.
  - finishST: `pwrP` -> shutDownST; `finishTime`==0 with `armed` set -> shutDownST.
- `armed` is cleared on every state change. In beginST it is set when `initTime`!=0 is sampled; in finishST it is set when `finishTime`!=0 is sampled. This masks stale or X countdown values left by the previous mode.
- `alarm` <= 1 on entry to errorST or finishST, and <= 0 on entry to any other state.

## Timing
- Reset: `state`=shutDownST, `alarm`=0, `armed`=0. Synchronizers, debounce counters, debounced levels and edge registers are all cleared to 0. Reset asserted mid-wash forces shutDownST immediately and asynchronously.
- Debounced button path: the debounced level flips after `DEBOUNCE_CYCLES` consecutive cycles of a stable synchronized value. The pulse is high for the cycle after that flip. `state` updates on the clock edge that samples the pulse. A continuously held button yields exactly one pulse.
- `lidS` lags `lidOpen` by 2 cycles. State responds on the next edge, so `state` reaches errorST 3 cycles after the lid opens.
- `hadFinish`, `initTime` and `finishTime` are sampled directly, with no synchronizer (same clock domain). Their response latency is 1 cycle.
- Simultaneous events:
  - `pwrP` with anything: `pwrP` wins.
  - `lidS` with `hadFinish` in runST: errorST wins.
  - `stP` with `hadFinish` in runST: finishST wins.

## Configuration
- `WASHER_DEBOUNCE_EN`
  - Defined: debounce counters are instantiated as described above.
  - Undefined: no counter. The pulse asserts 3 cycles after the raw rise (2 sync + edge). `DEBOUNCE_CYCLES` is ignored.
  - `lidOpen` is never debounced in either build.

## Structure
- Shared package `washer_pkg`: the seven state constants (shutDownST…finishST), shared with the run stage and the display, plus the 3-bit state typedef.
- Sub-module `btn_pulse`: synchronizer, optional debounce counter (width $clog2(DEBOUNCE_CYCLES+1)) and edge detector. It is instantiated twice, once for power and once for start.

## Test plan
- Reset, then a `powerBtn` press held 40 cycles -> exactly one transition to beginST, 2+16+1 cycles after the press. Then `initTime` 5->0 -> setST one cycle after 0 is seen.
- Enter beginST while `initTime` is already 0 (armed=0) -> state holds beginST until `initTime` becomes 5 and then returns to 0.
- In runST, raise `lidOpen` and `hadFinish` on the same cycle -> errorST and `alarm`=1. Lower the lid -> pauseST and `alarm`=0. Start press -> runST.
- In runST, `hadFinish`=1 -> finishST. `finishTime` 5..0 -> shutDownST. Power and start pulses coincident in setST -> shutDownST.
- Assert `rst` in runST mid-debounce -> `state`=0 immediately, no pulse emitted after release. Force `state`=7 -> shutDownST next cycle.
- Build without `WASHER_DEBOUNCE_EN`: a 1-cycle start glitch in setST -> runST after 3 cycles. The same glitch with the macro defined -> no transition.

Source files
------------

// File: rtl/washer_pkg.sv
// washer_pkg: mode constants and helpers shared by the mode controller,
// the run/countdown stage and the display.
package washer_pkg;

    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        shutDownST = 3'd0,
        beginST    = 3'd1,
        setST      = 3'd2,
        runST      = 3'd3,
        errorST    = 3'd4,
        pauseST    = 3'd5,
        finishST   = 3'd6
    } state_e;

    function automatic logic is_alarm(input state_e s);
        return (s == errorST) || (s == finishST);
    endfunction

endpackage

// File: rtl/washer_fsm_if.sv
// washer_fsm_if: mode bus between the controller and the run/countdown stage.
// master = mode controller, slave = run stage / display.
interface washer_fsm_if;
    import washer_pkg::*;

    state_e            state;
    logic              alarm;
    logic              hadFinish;
    logic [CNT_W-1:0]  initTime;
    logic [CNT_W-1:0]  finishTime;

    modport master (
        output state, alarm,
        input  hadFinish, initTime, finishTime
    );

    modport slave (
        input  state, alarm,
        output hadFinish, initTime, finishTime
    );

endinterface

// File: rtl/btn_pulse.sv
// btn_pulse: 2-FF sync, optional debounce (WASHER_DEBOUNCE_EN), rise pulse.
// Without the macro the pulse follows the synchronized level directly.
module btn_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    logic s1, s2, lvl, prv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

`ifdef WASHER_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // level flips on the Nth consecutive cycle of disagreement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            lvl <= 1'b0;
        end else if (s2 == lvl) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            lvl <= s2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign lvl = s2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prv <= 1'b0;
        else     prv <= lvl;
    end

    assign pulse = lvl & ~prv;

endmodule

// File: rtl/washer_fsm.sv
// washer_fsm: washing machine mode controller driving the run-stage bus.
// Button debounce is compiled in with WASHER_DEBOUNCE_EN.
module washer_fsm
    import washer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            powerBtn,
    input  logic            startBtn,
    input  logic            lidOpen,
    washer_fsm_if.master    bus
);

    logic   pwrP, stP;
    logic   lid1, lidS;
    state_e cur, nxt;
    logic   alarm_q;
    logic   armed, arm_nxt;

    btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pwr (
        .clk   (clk),
        .rst   (rst),
        .raw   (powerBtn),
        .pulse (pwrP)
    );

    btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_st (
        .clk   (clk),
        .rst   (rst),
        .raw   (startBtn),
        .pulse (stP)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lid1 <= 1'b0;
            lidS <= 1'b0;
        end else begin
            lid1 <= lidOpen;
            lidS <= lid1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= shutDownST;
            alarm_q <= 1'b0;
            armed   <= 1'b0;
        end else begin
            cur     <= nxt;
            alarm_q <= is_alarm(nxt);
            armed   <= arm_nxt;
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            shutDownST: if (pwrP) nxt = beginST;
            beginST: begin
                if (pwrP)                        nxt = shutDownST;
                else if (bus.initTime == '0 && armed) nxt = setST;
            end
            setST: begin
                if (pwrP)     nxt = shutDownST;
                else if (stP) nxt = runST;
            end
            runST: begin
                if (pwrP)               nxt = shutDownST;
                else if (lidS)          nxt = errorST;
                else if (bus.hadFinish) nxt = finishST;
                else if (stP)           nxt = pauseST;
            end
            pauseST: begin
                if (pwrP)              nxt = shutDownST;
                else if (stP && !lidS) nxt = runST;
            end
            errorST: begin
                if (pwrP)       nxt = shutDownST;
                else if (!lidS) nxt = pauseST;
            end
            finishST: begin
                if (pwrP)                               nxt = shutDownST;
                else if (bus.finishTime == '0 && armed) nxt = shutDownST;
            end
            default: nxt = shutDownST;
        endcase
    end

    // arming ignores countdown values left over from the previous mode
    always_comb begin
        arm_nxt = armed;
        if (nxt != cur)
            arm_nxt = 1'b0;
        else if (cur == beginST && bus.initTime != '0)
            arm_nxt = 1'b1;
        else if (cur == finishST && bus.finishTime != '0)
            arm_nxt = 1'b1;
    end

    assign bus.state = cur;
    assign bus.alarm = alarm_q;

endmodule

// File: tb/tb_washer_fsm.sv
// tb_washer_fsm: directed checks of the washer mode controller.
// Latencies follow the WASHER_DEBOUNCE_EN setting of the build.
module tb_washer_fsm;
    import washer_pkg::*;

`ifdef WASHER_DEBOUNCE_EN
    localparam int LAT = 19;
    localparam logic [2:0] GLITCH_ST = 3'd2;
`else
    localparam int LAT = 3;
    localparam logic [2:0] GLITCH_ST = 3'd3;
`endif

    logic clk = 1'b0;
    logic rst, powerBtn, startBtn, lidOpen;
    int   n_chk = 0;
    int   n_fail = 0;

    washer_fsm_if bus ();

    washer_fsm #(.DEBOUNCE_CYCLES(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .powerBtn (powerBtn),
        .startBtn (startBtn),
        .lidOpen  (lidOpen),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] got,
                       input logic [2:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit pwr, input bit st);
        powerBtn = pwr;
        startBtn = st;
        step(LAT);
        powerBtn = 1'b0;
        startBtn = 1'b0;
        step(LAT + 2);
    endtask

    task automatic to_set();
        press(1'b1, 1'b0);
        bus.initTime = 3'd5;
        step(1);
        bus.initTime = 3'd0;
        step(1);
    endtask

    initial begin
        rst = 1'b1;
        powerBtn = 1'b0;
        startBtn = 1'b0;
        lidOpen = 1'b0;
        bus.hadFinish = 1'b0;
        bus.initTime = 3'd0;
        bus.finishTime = 3'd0;
        step(2);
        chk("rst_state", bus.state, 3'd0);
        chk("rst_alarm", {2'b0, bus.alarm}, 3'd0);
        rst = 1'b0;
        step(1);

        powerBtn = 1'b1;
        step(LAT - 1);
        chk("pwr_early", bus.state, 3'd0);
        step(1);
        chk("pwr_begin", bus.state, 3'd1);
        step(40 - LAT);
        chk("pwr_held", bus.state, 3'd1);
        powerBtn = 1'b0;
        step(LAT + 2);
        chk("begin_unarmed", bus.state, 3'd1);

        bus.initTime = 3'd5;
        step(1);
        chk("begin_arming", bus.state, 3'd1);
        bus.initTime = 3'd0;
        step(1);
        chk("set_entry", bus.state, 3'd2);

        press(1'b0, 1'b1);
        chk("run_entry", bus.state, 3'd3);

        lidOpen = 1'b1;
        step(2);
        chk("lid_lag", bus.state, 3'd3);
        bus.hadFinish = 1'b1;
        step(1);
        bus.hadFinish = 1'b0;
        chk("lid_err", bus.state, 3'd4);
        chk("err_alarm", {2'b0, bus.alarm}, 3'd1);
        lidOpen = 1'b0;
        step(2);
        chk("err_hold", bus.state, 3'd4);
        step(1);
        chk("err_pause", bus.state, 3'd5);
        chk("pause_alarm", {2'b0, bus.alarm}, 3'd0);

        lidOpen = 1'b1;
        step(3);
        press(1'b0, 1'b1);
        chk("pause_lid_ign", bus.state, 3'd5);
        lidOpen = 1'b0;
        step(3);
        press(1'b0, 1'b1);
        chk("pause_run", bus.state, 3'd3);

        bus.hadFinish = 1'b1;
        step(1);
        bus.hadFinish = 1'b0;
        chk("fin_entry", bus.state, 3'd6);
        chk("fin_alarm", {2'b0, bus.alarm}, 3'd1);
        step(3);
        chk("fin_unarmed", bus.state, 3'd6);
        bus.finishTime = 3'd5;
        step(1);
        chk("fin_cnt5", bus.state, 3'd6);
        bus.finishTime = 3'd2;
        step(1);
        chk("fin_cnt2", bus.state, 3'd6);
        bus.finishTime = 3'd0;
        step(1);
        chk("fin_done", bus.state, 3'd0);
        chk("fin_alarm_off", {2'b0, bus.alarm}, 3'd0);

        to_set();
        chk("set_again", bus.state, 3'd2);
        press(1'b1, 1'b1);
        chk("pwr_wins", bus.state, 3'd0);

        to_set();
        press(1'b0, 1'b1);
        chk("run_again", bus.state, 3'd3);
        startBtn = 1'b1;
        step(2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", bus.state, 3'd0);
        startBtn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(LAT + 5);
        chk("rst_no_pulse", bus.state, 3'd0);

        to_set();
        startBtn = 1'b1;
        step(1);
        startBtn = 1'b0;
        step(1);
        chk("glitch_early", bus.state, 3'd2);
        step(1);
        chk("glitch", bus.state, GLITCH_ST);
        step(LAT + 4);
        chk("glitch_late", bus.state, GLITCH_ST);

        force dut.cur = state_e'(3'd7);
        #1;
        chk("forced7", bus.state, 3'd7);
        step(1);
        release dut.cur;
        step(1);
        chk("illegal_rec", bus.state, 3'd0);
        chk("illegal_alarm", {2'b0, bus.alarm}, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
